imem_port_arbiter: RTL and testbench

- Shares the single synchronous-read instruction memory port between the core fetch unit and a program loader/debug port (read and write).
- Sits between the fetch stage, the loader and the instruction memory.
- Grants one requester per cycle and returns read data after the memory's fixed 1-cycle latency, tagged to the correct requester.
- Loader has priority, bounded by a fetch anti-starvation limit and an exclusive lock mode.

---
 rtl/types_pkg.sv | 17 +
 rtl/imem_port_arbiter_if.sv | 49 ++++
 rtl/imem_starve_counter.sv | 39 +++
 rtl/imem_port_arbiter.sv | 99 +++++++++
 tb/tb_imem_port_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/types_pkg.sv
// Shared instruction-memory types and arbiter constants.
// Memory is word addressed; MEM_SIZE sets the address width.
package types_pkg;

   localparam int MEM_SIZE = 512;
   localparam int AW = $clog2(MEM_SIZE);
   localparam int IMEM_STARVE_LIMIT = 4;

   typedef logic [AW-1:0] address_t;
   typedef logic [31:0]   word_t;

   typedef enum logic {
      ARB,
      LOCKED
   } arb_state_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and memory-side signals of the imem port arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface imem_port_arbiter_if;
   import types_pkg::*;

   logic     f_req;
   address_t f_addr;
   logic     f_gnt;
   logic     f_rvalid;
   word_t    f_rdata;

   logic     l_req;
   logic     l_we;
   address_t l_addr;
   word_t    l_wdata;
   logic     l_lock;
   logic     l_gnt;
   logic     l_rvalid;
   word_t    l_rdata;

   logic     mem_en;
   logic     mem_we;
   address_t mem_addr;
   word_t    mem_wdata;
   word_t    mem_rdata;

   logic     fetch_stall;

   modport slave (
      input  f_req, f_addr,
      output f_gnt, f_rvalid, f_rdata,
      input  l_req, l_we, l_addr, l_wdata, l_lock,
      output l_gnt, l_rvalid, l_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output fetch_stall
   );

   modport master (
      output f_req, f_addr,
      input  f_gnt, f_rvalid, f_rdata,
      output l_req, l_we, l_addr, l_wdata, l_lock,
      input  l_gnt, l_rvalid, l_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  fetch_stall
   );

endinterface

// File: rtl/imem_starve_counter.sv
// Saturating count of consecutive denied fetch cycles.
// Clear wins over increment; hold freezes the count.
module imem_starve_counter #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   input  logic hold,
   output logic at_limit
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !hold && (cnt_q < LIM)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q >= LIM);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one 1-cycle-latency imem port between fetch and the loader.
// Loader has priority unless fetch is starved or the loader holds the lock.
module imem_port_arbiter
   import types_pkg::*;
#(
   parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT
) (
   input logic                clk,
   input logic                rst,
   imem_port_arbiter_if.slave bus
);

   arb_state_t state_q;
   arb_state_t state_d;
   logic       f_rvalid_q;
   logic       f_rvalid_d;
   logic       l_rvalid_q;
   logic       l_rvalid_d;

   logic       f_gnt;
   logic       l_gnt;
   logic       starved;
   logic       cnt_clr;
   logic       cnt_inc;

   always_comb begin
      state_d    = bus.l_lock ? LOCKED : ARB;
      f_gnt      = 1'b0;
      l_gnt      = 1'b0;
      if (!rst) begin
         case (state_q)
            ARB: begin
               if (starved) begin
                  f_gnt = bus.f_req;
                  l_gnt = bus.l_req & ~bus.f_req;
               end else begin
                  l_gnt = bus.l_req;
                  f_gnt = bus.f_req & ~bus.l_req;
               end
            end
            LOCKED: begin
               l_gnt = bus.l_req;
            end
            default: ;
         endcase
      end
      f_rvalid_d = f_gnt;
      l_rvalid_d = l_gnt & ~bus.l_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         f_rvalid_q <= f_rvalid_d;
         l_rvalid_q <= l_rvalid_d;
      end
   end

   // The count only builds while fetch waits in normal arbitration.
   assign cnt_clr = f_gnt | ~bus.f_req | (state_q == LOCKED);
   assign cnt_inc = bus.f_req & ~f_gnt & (state_q == ARB);

   imem_starve_counter #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .hold    (1'b0),
      .at_limit(starved)
   );

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (l_gnt) begin
         bus.mem_addr  = bus.l_addr;
         bus.mem_wdata = bus.l_wdata;
      end else if (f_gnt) begin
         bus.mem_addr  = bus.f_addr;
      end
   end

   assign bus.f_gnt       = f_gnt;
   assign bus.l_gnt       = l_gnt;
   assign bus.mem_en      = f_gnt | l_gnt;
   assign bus.mem_we      = l_gnt & bus.l_we;
   assign bus.f_rvalid    = f_rvalid_q;
   assign bus.l_rvalid    = l_rvalid_q;
   assign bus.f_rdata     = bus.mem_rdata;
   assign bus.l_rdata     = bus.mem_rdata;
   assign bus.fetch_stall = bus.f_req & ~f_gnt;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a behavioural memory.
// Expected grants come from an independent arbitration model.
module tb_imem_port_arbiter;
   import types_pkg::*;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_port_arbiter_if bus();

   imem_port_arbiter #(
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   word_t mem  [MEM_SIZE];
   word_t refm [MEM_SIZE];

   initial begin
      for (int i = 0; i < MEM_SIZE; i++) begin
         mem[i]  = 32'h1000_0000 + i * 32'h0001_0003;
         refm[i] = 32'h1000_0000 + i * 32'h0001_0003;
      end
   end

   initial bus.mem_rdata = '0;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   logic     m_lock;
   int       m_cnt;
   word_t    fq[$];
   word_t    lq[$];
   logic     ef;
   logic     el;
   address_t ea;
   word_t    ew;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_f_gnt", bus.f_gnt, 0);
         chk("rst_l_gnt", bus.l_gnt, 0);
         chk("rst_mem_en", bus.mem_en, 0);
         m_lock = 1'b0;
         m_cnt  = 0;
         fq.delete();
         lq.delete();
      end else begin
         chk("f_rvalid", bus.f_rvalid, fq.size() != 0);
         if (fq.size() != 0) chk("f_rdata", bus.f_rdata, fq.pop_front());
         chk("l_rvalid", bus.l_rvalid, lq.size() != 0);
         if (lq.size() != 0) chk("l_rdata", bus.l_rdata, lq.pop_front());

         if (m_lock) begin
            ef = 1'b0;
            el = bus.l_req;
         end else if (m_cnt >= LIMIT) begin
            ef = bus.f_req;
            el = bus.l_req & ~bus.f_req;
         end else begin
            el = bus.l_req;
            ef = bus.f_req & ~bus.l_req;
         end
         ea = el ? bus.l_addr : (ef ? bus.f_addr : '0);
         ew = el ? bus.l_wdata : '0;

         chk("f_gnt", bus.f_gnt, ef);
         chk("l_gnt", bus.l_gnt, el);
         chk("mem_en", bus.mem_en, ef | el);
         chk("mem_we", bus.mem_we, el & bus.l_we);
         chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
         chk("mem_wdata", bus.mem_wdata, ew);
         chk("fetch_stall", bus.fetch_stall, bus.f_req & ~ef);

         if (ef) fq.push_back(refm[bus.f_addr]);
         if (el && !bus.l_we) lq.push_back(refm[bus.l_addr]);
         if (el && bus.l_we) refm[bus.l_addr] = bus.l_wdata;

         if (m_lock || ef || !bus.f_req) m_cnt = 0;
         else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
         m_lock = bus.l_lock;
      end
   end

   task automatic cyc(input logic fr, input int fa, input logic lr,
                      input logic lwe, input int la,
                      input logic [31:0] lwd, input logic lk);
      bus.f_req   = fr;
      bus.f_addr  = address_t'(fa);
      bus.l_req   = lr;
      bus.l_we    = lwe;
      bus.l_addr  = address_t'(la);
      bus.l_wdata = lwd;
      bus.l_lock  = lk;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);

      for (int i = 0; i < 3; i++) cyc(1, i, 0, 0, 0, 0, 0);
      idle(2);

      cyc(0, 0, 1, 1, 5, 32'hDEAD_BEEF, 0);
      cyc(1, 5, 0, 0, 0, 0, 0);
      idle(2);

      repeat (7) cyc(1, 3, 1, 0, 7, 0, 0);
      idle(2);

      repeat (20) cyc(1, 4, 0, 0, 0, 0, 1);
      cyc(1, 4, 0, 0, 0, 0, 0);
      cyc(1, 4, 0, 0, 0, 0, 0);
      idle(2);

      cyc(0, 0, 1, 0, 9, 0, 0);
      rst = 1'b1;
      cyc(1, 1, 1, 0, 2, 0, 0);
      rst = 1'b0;
      idle(2);

      cyc(0, 0, 1, 0, 'h1FF, 0, 0);
      idle(2);

      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         cyc($urandom_range(0, 1), $urandom_range(0, MEM_SIZE - 1),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, MEM_SIZE - 1), $urandom,
             $urandom_range(0, 9) == 0);
      end
      rst = 1'b0;
      idle(3);

      chk("fq_drained", fq.size(), 0);
      chk("lq_drained", lq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
